// File: rtl/fnd_scan_driver.sv
// Multiplexed 7-segment scan driver with frame-synchronous double-buffered display.
// Optional leading-zero blanking is enabled by defining FND_LZ_BLANK_EN.
module fnd_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000
) (
    input  logic                      i_Clk,
    input  logic                      i_Rst,
    input  logic                      i_Load,
    input  logic [4*NUM_DIGITS-1:0]   i_Data,
    input  logic [NUM_DIGITS-1:0]     i_DP,
    output logic [6:0]                o_FND,
    output logic                      o_DP,
    output logic [NUM_DIGITS-1:0]     o_COM,
    output logic                      o_Frame
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] D_LAST = DW'(NUM_DIGITS - 1);

    logic [PW-1:0]             p_q, p_d;
    logic [DW-1:0]             d_q, d_d;
    logic [4*NUM_DIGITS-1:0]   shadow_q, shadow_d, disp_q, disp_d;
    logic [NUM_DIGITS-1:0]     shadow_dp_q, shadow_dp_d, disp_dp_q, disp_dp_d;
    logic                      pend_q, pend_d;
    logic [6:0]                fnd_q, fnd_d;
    logic                      dp_q, dp_d;
    logic [NUM_DIGITS-1:0]     com_q, com_d;
    logic                      frame_q, frame_d;

    logic                      p_wrap_s, boundary_s;
    logic [3:0]                nib_s;
    logic                      dp_bit_s;
    logic [NUM_DIGITS-1:0]     com_sel_s;
    logic [NUM_DIGITS-1:0]     lz_mask_s;
    logic                      lead_s;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1011000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0011000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b0100111;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            4'hF:    seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    // Scan counters and the shadow/display double buffer.
    always_comb begin
        p_wrap_s    = (p_q == P_LAST);
        boundary_s  = p_wrap_s && (d_q == D_LAST);
        p_d         = p_wrap_s ? '0 : p_q + PW'(1);
        d_d         = d_q;
        shadow_d    = shadow_q;
        shadow_dp_d = shadow_dp_q;
        disp_d      = disp_q;
        disp_dp_d   = disp_dp_q;
        pend_d      = pend_q;
        if (p_wrap_s) begin
            d_d = boundary_s ? '0 : d_q + DW'(1);
        end else begin
            d_d = d_q;
        end
        if (i_Load && boundary_s) begin
            shadow_d    = i_Data;
            shadow_dp_d = i_DP;
            disp_d      = i_Data;
            disp_dp_d   = i_DP;
            pend_d      = 1'b0;
        end else if (i_Load) begin
            shadow_d    = i_Data;
            shadow_dp_d = i_DP;
            pend_d      = 1'b1;
        end else if (boundary_s && pend_q) begin
            disp_d    = shadow_q;
            disp_dp_d = shadow_dp_q;
            pend_d    = 1'b0;
        end else begin
            pend_d = pend_q;
        end
    end

    // Segment/common selection for the current slot, with the P==0 guard cycle blanked.
    always_comb begin
        nib_s     = 4'h0;
        dp_bit_s  = 1'b0;
        com_sel_s = '1;
        lz_mask_s = '0;
        lead_s    = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (d_q == DW'(k)) begin
                nib_s        = disp_q[4*k +: 4];
                dp_bit_s     = disp_dp_q[k];
                com_sel_s[k] = 1'b0;
            end else begin
                com_sel_s[k] = 1'b1;
            end
        end
`ifdef FND_LZ_BLANK_EN
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            if (lead_s && (disp_q[4*k +: 4] == 4'h0)) begin
                lz_mask_s[k] = 1'b1;
            end else begin
                lead_s = 1'b0;
            end
        end
`endif
        frame_d = boundary_s;
        if (p_q == '0) begin
            com_d = '1;
            fnd_d = 7'b1111111;
            dp_d  = 1'b1;
        end else begin
            com_d = com_sel_s;
            fnd_d = (|(lz_mask_s & ~com_sel_s)) ? 7'b1111111 : seg_decode(nib_s);
            dp_d  = ~dp_bit_s;
        end
    end

    // State and output registers.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            p_q         <= '0;
            d_q         <= '0;
            shadow_q    <= '0;
            shadow_dp_q <= '0;
            disp_q      <= '0;
            disp_dp_q   <= '0;
            pend_q      <= 1'b0;
            fnd_q       <= 7'b1111111;
            dp_q        <= 1'b1;
            com_q       <= '1;
            frame_q     <= 1'b0;
        end else begin
            p_q         <= p_d;
            d_q         <= d_d;
            shadow_q    <= shadow_d;
            shadow_dp_q <= shadow_dp_d;
            disp_q      <= disp_d;
            disp_dp_q   <= disp_dp_d;
            pend_q      <= pend_d;
            fnd_q       <= fnd_d;
            dp_q        <= dp_d;
            com_q       <= com_d;
            frame_q     <= frame_d;
        end
    end

    assign o_FND   = fnd_q;
    assign o_DP    = dp_q;
    assign o_COM   = com_q;
    assign o_Frame = frame_q;

endmodule
